// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO PHY-side responder: oversamples MDC/MDIO, decodes read/write
// frames against a 32x16 register file; register 1 reads come live from status_reg1.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADR      = 5'd1,
    parameter int unsigned PREAMBLE_LEN = 32,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic [15:0] status_reg1,
    output logic        wr_strobe,
    output logic [4:0]  wr_adr,
    output logic [15:0] wr_data,
    output logic        busy
);
    localparam int unsigned PRE_W    = $clog2(PREAMBLE_LEN + 1);
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned MDC_W    = SYNC_STAGES + 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PREAMBLE_LEN);
    localparam logic [CNT_W-1:0] SKIP_RD  = CNT_W'(18);
    localparam logic [CNT_W-1:0] SKIP_WR  = CNT_W'(16);

    typedef enum logic [3:0] {
        S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD,
        S_TA_RD, S_RD_DATA, S_TA_WR, S_WR_DATA, S_SKIP
    } state_t;

    state_t                 state, state_nxt;
    logic [MDC_W-1:0]       mdc_pipe;
    logic [SYNC_STAGES-1:0] mdio_pipe;
    logic [PRE_W-1:0]       pre_cnt, pre_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [14:0]            sh, sh_nxt;
    logic [15:0]            rd_data, rd_nxt;
    logic [4:0]             phy_adr_q, phy_nxt, reg_adr_q, reg_nxt;
    logic                   is_rd, is_rd_nxt;
    logic                   busy_nxt, oe_nxt, o_nxt, strobe_nxt, reg_we;
    logic [4:0]             wr_adr_nxt;
    logic [15:0]            wr_data_nxt;
    logic [15:0]            regs [32];

    logic        mdc_s, mdc_q, mdio_s, rise, fall, shifting;
    logic [1:0]  pair_in;
    logic [4:0]  adr_in;
    logic [15:0] word_in;

    // Edges come from the last two synchronized MDC samples
    assign mdc_s    = mdc_pipe[SYNC_STAGES-1];
    assign mdc_q    = mdc_pipe[SYNC_STAGES];
    assign mdio_s   = mdio_pipe[SYNC_STAGES-1];
    assign rise     = mdc_s & ~mdc_q;
    assign fall     = ~mdc_s & mdc_q;
    assign word_in  = {sh, mdio_s};
    assign adr_in   = word_in[4:0];
    assign pair_in  = word_in[1:0];
    assign shifting = rise && (state inside {S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA_WR, S_WR_DATA});

    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_pipe  <= '0;
            mdio_pipe <= '1;
        end else begin
            mdc_pipe  <= MDC_W'({mdc_pipe, mdc});
            mdio_pipe <= SYNC_STAGES'({mdio_pipe, mdio_i});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (rise && !mdio_s && pre_cnt >= PRE_MAX) state_nxt = S_ST2;
            S_ST2:     if (rise) state_nxt = mdio_s ? S_OP : S_IDLE;
            S_OP:      if (rise && cnt == 5'd1)
                           state_nxt = (pair_in == 2'b10 || pair_in == 2'b01) ? S_PHYAD : S_IDLE;
            S_PHYAD:   if (rise && cnt == 5'd4) state_nxt = S_REGAD;
            S_REGAD:   if (rise && cnt == 5'd4)
                           state_nxt = (phy_adr_q != PHY_ADR) ? S_SKIP : (is_rd ? S_TA_RD : S_TA_WR);
            S_TA_RD:   if (fall && cnt == 5'd1) state_nxt = S_RD_DATA;
            S_RD_DATA: if (fall && cnt == 5'd16) state_nxt = S_IDLE;
            S_TA_WR:   if (rise && cnt == 5'd1) state_nxt = (pair_in == 2'b10) ? S_WR_DATA : S_SKIP;
            S_WR_DATA: if (rise && cnt == 5'd15) state_nxt = S_IDLE;
            S_SKIP:    if (rise && cnt == 5'd1) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt     = cnt;
        sh_nxt      = sh;
        pre_nxt     = pre_cnt;
        busy_nxt    = busy;
        oe_nxt      = mdio_oe;
        o_nxt       = mdio_o;
        rd_nxt      = rd_data;
        is_rd_nxt   = is_rd;
        phy_nxt     = phy_adr_q;
        reg_nxt     = reg_adr_q;
        strobe_nxt  = 1'b0;
        reg_we      = 1'b0;
        wr_adr_nxt  = wr_adr;
        wr_data_nxt = wr_data;
        if (shifting) begin
            sh_nxt  = word_in[14:0];
            cnt_nxt = cnt + 1'b1;
        end
        case (state)
            S_IDLE: if (rise) begin
                if (mdio_s) begin
                    if (pre_cnt < PRE_MAX) pre_nxt = pre_cnt + 1'b1;
                end else if (pre_cnt >= PRE_MAX) begin
                    busy_nxt = 1'b1;
                end else begin
                    pre_nxt = '0;
                end
            end
            S_OP:    if (rise && cnt == 5'd1) is_rd_nxt = (pair_in == 2'b10);
            S_PHYAD: if (rise && cnt == 5'd4) phy_nxt = adr_in;
            S_REGAD: if (rise && cnt == 5'd4) begin
                reg_nxt = adr_in;
                rd_nxt  = (adr_in == 5'd1) ? status_reg1 : regs[adr_in];
            end
            // Second turnaround fall drives the TA zero
            S_TA_RD: if (fall) begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == 5'd1) begin
                    oe_nxt = 1'b1;
                    o_nxt  = 1'b0;
                end
            end
            S_RD_DATA: if (fall && cnt != 5'd16) begin
                o_nxt   = rd_data[15];
                rd_nxt  = {rd_data[14:0], 1'b0};
                cnt_nxt = cnt + 1'b1;
            end
            S_WR_DATA: if (rise && cnt == 5'd15 && reg_adr_q != 5'd1) begin
                reg_we      = 1'b1;
                strobe_nxt  = 1'b1;
                wr_adr_nxt  = reg_adr_q;
                wr_data_nxt = word_in;
            end
            S_SKIP: if (rise) cnt_nxt = cnt - 1'b1;
            default: ;
        endcase
        if (state_nxt != state) cnt_nxt = '0;
        if (state_nxt == S_SKIP && state != S_SKIP) cnt_nxt = (state == S_REGAD) ? SKIP_RD : SKIP_WR;
        if (state_nxt == S_IDLE && state != S_IDLE) begin
            pre_nxt  = '0;
            busy_nxt = 1'b0;
            oe_nxt   = 1'b0;
            o_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            sh        <= '0;
            pre_cnt   <= '0;
            busy      <= 1'b0;
            mdio_oe   <= 1'b0;
            mdio_o    <= 1'b1;
            rd_data   <= '0;
            is_rd     <= 1'b0;
            phy_adr_q <= '0;
            reg_adr_q <= '0;
            wr_strobe <= 1'b0;
            wr_adr    <= '0;
            wr_data   <= '0;
        end else begin
            cnt       <= cnt_nxt;
            sh        <= sh_nxt;
            pre_cnt   <= pre_nxt;
            busy      <= busy_nxt;
            mdio_oe   <= oe_nxt;
            mdio_o    <= o_nxt;
            rd_data   <= rd_nxt;
            is_rd     <= is_rd_nxt;
            phy_adr_q <= phy_nxt;
            reg_adr_q <= reg_nxt;
            wr_strobe <= strobe_nxt;
            wr_adr    <= wr_adr_nxt;
            wr_data   <= wr_data_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[wr_adr_nxt] <= wr_data_nxt;
        end
    end
endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: bit-banged SMI master, frame-level model of
// accept/write/read outcomes, and a per-cycle monitor of bus drive and strobes.
module tb_mdio_phy_responder;
    localparam logic [4:0] PHY  = 5'd1;
    localparam int         HALF = 5;

    logic        clk = 1'b0;
    logic        rst, mdc, m_drive, m_val, oe_allowed;
    logic        mdio_o, mdio_oe, wr_strobe, busy;
    logic [15:0] status_reg1, wr_data;
    logic [4:0]  wr_adr;
    wire         mdio_wire;

    logic [15:0] model_regs [32];
    logic [20:0] strobe_q [$];
    logic [20:0] last_wr;
    int          checks = 0;
    int          errors = 0;

    // Open-drain bus with pull-up: master drive wins, else PHY, else 1
    assign mdio_wire = m_drive ? m_val : (mdio_oe ? mdio_o : 1'b1);

    always #5 clk = ~clk;

    mdio_phy_responder #(.PHY_ADR(PHY), .PREAMBLE_LEN(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_wire),
        .mdio_o(mdio_o), .mdio_oe(mdio_oe), .status_reg1(status_reg1),
        .wr_strobe(wr_strobe), .wr_adr(wr_adr), .wr_data(wr_data), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle monitor: no drive outside an expected read window, one-clk strobes
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!oe_allowed) chk("oe_outside_read", 32'(mdio_oe), 32'(0));
            if (wr_strobe) begin
                chk("strobe_width", 32'(prev), 32'(0));
                strobe_q.push_back({wr_adr, wr_data});
            end
            prev = wr_strobe;
        end
    end

    task automatic mdc_cycle(input logic drv, input logic val, output logic wire_s, output logic busy_s);
        mdc = 1'b0;
        m_drive = drv;
        m_val = val;
        repeat (HALF) @(negedge clk);
        wire_s = mdio_wire;
        busy_s = busy;
        mdc = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model_regs[i] = 16'h0000;
        last_wr = '0;
    endtask

    task automatic run_frame(input int pre_len, input logic [1:0] st, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] ra, input logic [1:0] ta,
                             input logic [15:0] data, input int abort_at, output logic [15:0] rd_got);
        logic [31:0] body;
        logic [17:0] cap, exp_cap;
        logic [15:0] exp_data;
        logic        accepted, match, rd, wr, w, bz, rel;
        body     = {st, op, phy, ra, ta, data};
        accepted = (pre_len >= 32) && (st == 2'b01) && (op == 2'b01 || op == 2'b10);
        match    = accepted && (phy == PHY);
        rd       = match && (op == 2'b10);
        wr       = match && (op == 2'b01) && (ta == 2'b10) && (ra != 5'd1);
        exp_data = (ra == 5'd1) ? status_reg1 : model_regs[ra];
        cap      = '1;
        rd_got   = '0;
        strobe_q.delete();
        // Two zeros return the responder to a clean idle with an empty preamble count
        mdc_cycle(1'b1, 1'b0, w, bz);
        mdc_cycle(1'b1, 1'b0, w, bz);
        for (int i = 0; i < pre_len; i++) mdc_cycle(1'b1, 1'b1, w, bz);
        for (int b = 0; b < 32; b++) begin
            if (abort_at >= 0 && b == 16 + abort_at) begin
                mdc = 1'b0;
                m_drive = 1'b0;
                repeat (HALF) @(negedge clk);
                chk("abort_pre_oe", 32'(mdio_oe), 32'(1));
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk("abort_oe", 32'(mdio_oe), 32'(0));
                chk("abort_busy", 32'(busy), 32'(0));
                @(negedge clk);
                rst = 1'b0;
                oe_allowed = 1'b0;
                clear_model();
                repeat (4) @(negedge clk);
                chk("abort_wr_out", 32'({wr_adr, wr_data}), 32'(0));
                return;
            end
            rel = (op == 2'b10) && (b >= 14);
            if (rd && b == 15) oe_allowed = 1'b1;
            mdc_cycle(!rel, body[31-b], w, bz);
            if (b >= 14) cap[31-b] = w;
            if (b == 14) chk("busy_in_frame", 32'(bz), 32'(accepted));
        end
        mdc = 1'b0;
        m_drive = 1'b0;
        repeat (6) @(negedge clk);
        oe_allowed = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_end", 32'(busy), 32'(0));
        chk("oe_end", 32'(mdio_oe), 32'(0));
        exp_cap = rd ? {2'b10, exp_data} : '1;
        if (op == 2'b10) chk("read_wire", 32'(cap), 32'(exp_cap));
        chk("strobe_count", 32'(strobe_q.size()), 32'(wr));
        if (wr) begin
            if (strobe_q.size() > 0) chk("strobe_payload", 32'(strobe_q[0]), 32'({ra, data}));
            model_regs[ra] = data;
            last_wr = {ra, data};
        end
        chk("wr_hold", 32'({wr_adr, wr_data}), 32'(last_wr));
        rd_got = cap[15:0];
    endtask

    initial begin
        logic [15:0] got;
        logic [1:0]  st, op, ta;
        logic [4:0]  phy, ra;
        logic [15:0] d;
        int          pl;
        rst = 1'b1; mdc = 1'b0; m_drive = 1'b1; m_val = 1'b1;
        oe_allowed = 1'b0; status_reg1 = 16'h0000;
        clear_model();
        repeat (4) @(negedge clk);
        chk("rst_oe", 32'(mdio_oe), 32'(0));
        chk("rst_o", 32'(mdio_o), 32'(1));
        chk("rst_strobe", 32'(wr_strobe), 32'(0));
        chk("rst_wr_adr", 32'(wr_adr), 32'(0));
        chk("rst_wr_data", 32'(wr_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        repeat (4) @(negedge clk);

        run_frame(32, 2'b01, 2'b01, PHY, 5'd31, 2'b10, 16'h0007, -1, got);
        chk("lit_wr31", 32'({wr_adr, wr_data}), 32'({5'd31, 16'h0007}));
        run_frame(32, 2'b01, 2'b10, PHY, 5'd31, 2'b00, 16'h0000, -1, got);
        chk("lit_rd31", 32'(got), 32'(16'h0007));

        status_reg1 = 16'h0004;
        run_frame(32, 2'b01, 2'b10, PHY, 5'd1, 2'b00, 16'h0000, -1, got);
        chk("lit_rd1", 32'(got), 32'(16'h0004));
        run_frame(32, 2'b01, 2'b01, PHY, 5'd1, 2'b10, 16'hFFFF, -1, got);
        run_frame(32, 2'b01, 2'b10, PHY, 5'd1, 2'b00, 16'h0000, -1, got);
        chk("lit_rd1_again", 32'(got), 32'(16'h0004));

        run_frame(32, 2'b01, 2'b10, 5'd2, 5'd31, 2'b00, 16'h0000, -1, got);
        chk("lit_other_phy", 32'(got), 32'(16'hFFFF));
        run_frame(32, 2'b01, 2'b10, PHY, 5'd31, 2'b00, 16'h0000, -1, got);
        chk("lit_rd31_after_skip", 32'(got), 32'(16'h0007));

        run_frame(31, 2'b01, 2'b01, PHY, 5'd5, 2'b10, 16'h1234, -1, got);
        run_frame(32, 2'b01, 2'b10, PHY, 5'd5, 2'b00, 16'h0000, -1, got);
        chk("lit_short_pre_ignored", 32'(got), 32'(16'h0000));
        run_frame(32, 2'b01, 2'b01, PHY, 5'd5, 2'b10, 16'h1234, -1, got);
        run_frame(32, 2'b01, 2'b10, PHY, 5'd5, 2'b00, 16'h0000, -1, got);
        chk("lit_rd5", 32'(got), 32'(16'h1234));

        run_frame(32, 2'b01, 2'b01, PHY, 5'd5, 2'b11, 16'h5555, -1, got);
        run_frame(32, 2'b01, 2'b10, PHY, 5'd5, 2'b00, 16'h0000, -1, got);
        chk("lit_rd5_bad_ta", 32'(got), 32'(16'h1234));
        run_frame(32, 2'b01, 2'b11, PHY, 5'd5, 2'b10, 16'h5555, -1, got);

        run_frame(32, 2'b01, 2'b01, PHY, 5'd10, 2'b10, 16'hA5A5, -1, got);
        run_frame(32, 2'b01, 2'b10, PHY, 5'd10, 2'b00, 16'h0000, 8, got);
        run_frame(32, 2'b01, 2'b10, PHY, 5'd10, 2'b00, 16'h0000, -1, got);
        chk("lit_rd10_after_rst", 32'(got), 32'(16'h0000));
        run_frame(32, 2'b01, 2'b10, PHY, 5'd31, 2'b00, 16'h0000, -1, got);
        chk("lit_rd31_after_rst", 32'(got), 32'(16'h0000));
        run_frame(32, 2'b01, 2'b01, PHY, 5'd3, 2'b10, 16'h3C3C, -1, got);
        run_frame(32, 2'b01, 2'b10, PHY, 5'd3, 2'b00, 16'h0000, -1, got);
        chk("lit_rd3", 32'(got), 32'(16'h3C3C));

        for (int n = 0; n < 30; n++) begin
            pl  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(28, 31)) : int'($urandom_range(32, 34));
            st  = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'b01;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = 2'b01;
                4, 5, 6, 7: op = 2'b10;
                default:    op = 2'($urandom());
            endcase
            phy = ($urandom_range(0, 4) == 0) ? 5'($urandom()) : PHY;
            ra  = ($urandom_range(0, 3) == 0) ? 5'd1 : 5'($urandom_range(0, 7));
            ta  = ($urandom_range(0, 5) == 0) ? 2'($urandom()) : 2'b10;
            d   = 16'($urandom());
            status_reg1 = 16'($urandom());
            run_frame(pl, st, op, phy, ra, ta, d, -1, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- PHY-side MDIO management responder (Clause 22) for bench and loopback builds; answers read and write frames issued by the SMI master.
- Oversamples MDC/MDIO on the system clock, decodes frames and holds a 32x16 register file.
- Register 1 is read-only and is sourced live from the `status_reg1` input.
- Drives MDIO only during read turnaround and read data, through an open-drain-style output enable.

Parameters:
- PHY_ADR, 5'd1: PHY address this responder answers to.
- PREAMBLE_LEN, 32: minimum consecutive 1 bits required before ST.
- SYNC_STAGES, 2: synchronizer depth for MDC and MDIO (both use the same depth).

Ports:
- clk  in  1  system clock; must be at least 8x MDC.
- rst  in  1  reset; synchronous, active-high.
- mdc  in  1  management clock from the master.
- mdio_i  in  1  MDIO pad input.
- mdio_o  out  1  MDIO drive value; only meaningful while mdio_oe=1.
- mdio_oe  out  1  MDIO output enable; pad is Z when 0.
- status_reg1  in  16  value returned for reads of register 1.
- wr_strobe  out  1  one-clk pulse when a register is written.
- wr_adr  out  5  register address of the last write.
- wr_data  out  16  data of the last write.
- busy  out  1  high from ST detected until frame end or abort.

Behaviour:
- Reset (synchronous, rst=1):
  - mdio_oe=0, mdio_o=1, wr_strobe=0, wr_adr=0, wr_data=0, busy=0.
  - Register file cleared to 0, except reg 31 = 16'h0000 and reg 16 = 16'h0000; all registers are 0.
  - Preamble counter = 0, FSM = IDLE.
  - Reset mid-frame aborts immediately and releases the bus in the same clk.
- Sampling:
  - mdc and mdio_i pass through SYNC_STAGES flops.
  - Rise/fall of MDC is detected from the last two synced samples.
  - MDIO is sampled on the detected MDC rise.
  - Outputs change on the clk after a detected MDC fall.
- FSM (each step consumes one sampled bit on an MDC rise):
  - IDLE: a 1 increments the preamble count, saturating at PREAMBLE_LEN. A 0 with count>=PREAMBLE_LEN goes to ST2 and sets busy=1. A 0 with count<PREAMBLE_LEN clears the count and stays in IDLE.
  - ST2: expects 1, else go to IDLE.
  - OP (2 bits): 10 = read, 01 = write; 00 or 11 goes to IDLE.
  - PHYAD (5 bits, MSB first). REGAD (5 bits, MSB first).
  - After REGAD: if PHYAD != PHY_ADR, go to SKIP (18 bits). Otherwise go to TA_RD or TA_WR.
  - On entering TA_RD, latch read data: status_reg1 if REGAD=1, else regs[REGAD].
  - TA_RD:
    - First fall after the REGAD sample: mdio_oe stays 0.
    - Next fall: mdio_oe=1, mdio_o=0.
  - RD_DATA: on each of the 16 following falls, drive the next data bit MSB first. On the fall after the 16th data rise, mdio_oe=0, then go to IDLE.
  - TA_WR: sample 2 bits. If they are not 1,0, go to SKIP (16 bits) and do not write.
  - WR_DATA: shift 16 bits MSB first. On the 16th rise:
    - If REGAD != 1, write the register file and pulse wr_strobe for one clk with wr_adr/wr_data.
    - REGAD = 1 writes are dropped silently: no strobe.
    - Then go to IDLE.
  - SKIP: count the remaining bits with mdio_oe held 0, then go to IDLE.
- Frame end (IDLE entry) clears the preamble count and busy. Every frame needs a full preamble; preamble suppression is not supported.
- mdio_oe is never 1 outside TA_RD/RD_DATA for a matching PHYAD.
- Read latency: first driven bit (TA 0) appears <= SYNC_STAGES+2 clk after the MDC fall that follows the TA first-bit rise.

Test Plan:
- Write reg 31 = 16'h0007, then read reg 31 (PHY 1) -> wr_strobe one clk with wr_adr=31, wr_data=0007; read returns TA 0 then 0000000000000111, and mdio_oe drops after bit 16.
- status_reg1=16'h0004, read reg 1 -> serial data 0x0004; a write of 16'hFFFF to reg 1 -> no wr_strobe, and a re-read still returns 0x0004.
- Read with PHYAD=2 -> mdio_oe stays 0 for the whole frame, busy returns 0 after 64 MDC; a following PHY 1 frame works normally.
- Preamble of 31 ones, then a valid frame body -> ignored (no strobe, no drive); the same body with 32 ones is accepted.
- Write frame with TA=11 -> no strobe, register unchanged; OP=11 -> FSM back to IDLE, busy=0.
- Assert rst during the RD_DATA bit 8 -> mdio_oe=0 in the same clk, busy=0, all registers 0; the next full frame decodes correctly.
